// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache.
package icache_assoc_pkg;

    // Default geometry
    localparam int unsigned ICACHE_WAYS       = 2;
    localparam int unsigned ICACHE_SETS       = 64;
    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned ICACHE_ADDR_W     = 32;

    // Refill controller states
    typedef enum logic [0:0] {
        StIdle,
        StRefill
    } ic_state_e;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_assoc_if #(
    parameter int unsigned ADDR_W = 32
) ();
    // Fetch unit <-> cache
    logic              if_to_ic_req_valid;
    logic [ADDR_W-1:0] if_to_ic_req_addr;
    logic              ic_to_if_req_ready;
    logic              ic_to_if_resp_valid;
    logic [31:0]       ic_to_if_resp_inst;
    logic              if_to_ic_clear;
    logic              if_to_ic_invalidate;
    // Cache <-> memory controller
    logic              ic_to_mc_req_valid;
    logic [ADDR_W-1:0] ic_to_mc_req_addr;
    logic              mc_to_ic_resp_valid;
    logic [31:0]       mc_to_ic_resp_data;

    // Cache side
    modport slave (
        input  if_to_ic_req_valid, if_to_ic_req_addr, if_to_ic_clear, if_to_ic_invalidate,
        input  mc_to_ic_resp_valid, mc_to_ic_resp_data,
        output ic_to_if_req_ready, ic_to_if_resp_valid, ic_to_if_resp_inst,
        output ic_to_mc_req_valid, ic_to_mc_req_addr
    );

    // Fetch unit and memory controller side
    modport master (
        output if_to_ic_req_valid, if_to_ic_req_addr, if_to_ic_clear, if_to_ic_invalidate,
        output mc_to_ic_resp_valid, mc_to_ic_resp_data,
        input  ic_to_if_req_ready, ic_to_if_resp_valid, ic_to_if_resp_inst,
        input  ic_to_mc_req_valid, ic_to_mc_req_addr
    );
endinterface

// File: rtl/icache_assoc_way.sv
// One cache way: valid/tag/data storage, tag compare and word read/write ports.
module icache_assoc_way
    import icache_assoc_pkg::*;
#(
    parameter int unsigned SETS       = ICACHE_SETS,
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int unsigned TAG_W      = 22,
    localparam int unsigned SB        = $clog2(SETS),
    localparam int unsigned WB        = $clog2(LINE_WORDS)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    // lookup
    input  logic [SB-1:0]    rd_set,
    input  logic [WB-1:0]    rd_word,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic             set_valid,
    output logic [31:0]      rd_data,
    // refill
    input  logic             wr_en,
    input  logic [SB-1:0]    wr_set,
    input  logic [WB-1:0]    wr_word,
    input  logic [31:0]      wr_data,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_all
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*LINE_WORDS];

    assign set_valid = valid_q[rd_set];
    assign hit       = valid_q[rd_set] && (tag_q[rd_set] == rd_tag);
    assign rd_data   = data_q[{rd_set, rd_word}];

    // Valid bits: cleared by reset or invalidate, set when a line installs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[wr_set] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity gates their use.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            data_q[{wr_set, wr_word}] <= wr_data;
        end
        if (fill_en) begin
            tag_q[wr_set] <= fill_tag;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: hit path, refill FSM, round-robin replacement.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int unsigned WAYS       = ICACHE_WAYS,
    parameter int unsigned SETS       = ICACHE_SETS,
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int unsigned ADDR_W     = ICACHE_ADDR_W
) (
    input logic           clk_in,
    input logic           rst_in,
    input logic           rdy_in,
    icache_assoc_if.slave bus
);

    localparam int unsigned WB    = $clog2(LINE_WORDS);
    localparam int unsigned SB    = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - WB - SB;
    localparam int unsigned VW    = idx_w(WAYS);

    ic_state_e               state_q, state_d;
    logic [ADDR_W-1:0]       miss_addr_q, miss_addr_d;
    logic [WB-1:0]           k_q, k_d;
    logic [VW-1:0]           victim_q, victim_d;
    logic                    kill_q, kill_d;
    logic                    inv_pend_q, inv_pend_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_inst_q, resp_inst_d;
    logic [SETS-1:0][VW-1:0] ptr_q;

    logic [ADDR_W-1:0] lk_addr;
    logic [SB-1:0]     lk_set;
    logic [WB-1:0]     lk_word;
    logic [TAG_W-1:0]  lk_tag;
    logic              ready, accept, last_word;
    logic              wr_any, fill_any, inv_all, ptr_inc;
    logic [VW-1:0]     ptr_next;

    logic              way_hit   [WAYS];
    logic              way_valid [WAYS];
    logic [31:0]       way_rdata [WAYS];
    logic              hit_any, inv_found;
    logic [31:0]       hit_data;
    logic [VW-1:0]     inv_way;

    // Only word address bits take part in lookup.
    logic unused_lk;
    assign unused_lk = ^lk_addr[1:0];

    // During refill the ways are looked up with the latched miss address.
    assign lk_addr   = (state_q == StIdle) ? bus.if_to_ic_req_addr : miss_addr_q;
    assign lk_set    = lk_addr[2+WB +: SB];
    assign lk_word   = lk_addr[2 +: WB];
    assign lk_tag    = lk_addr[ADDR_W-1 -: TAG_W];

    assign ready     = rst_in & rdy_in & (state_q == StIdle) & ~bus.if_to_ic_clear &
                       ~bus.if_to_ic_invalidate & ~inv_pend_q;
    assign accept    = ready & bus.if_to_ic_req_valid;
    assign last_word = (k_q == WB'(LINE_WORDS - 1));
    assign ptr_next  = (ptr_q[lk_set] == VW'(WAYS - 1)) ? '0 : ptr_q[lk_set] + 1'b1;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_assoc_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .rd_set    (lk_set),
            .rd_word   (lk_word),
            .rd_tag    (lk_tag),
            .hit       (way_hit[w]),
            .set_valid (way_valid[w]),
            .rd_data   (way_rdata[w]),
            .wr_en     (rdy_in & wr_any & (victim_q == VW'(w))),
            .wr_set    (miss_addr_q[2+WB +: SB]),
            .wr_word   (k_q),
            .wr_data   (bus.mc_to_ic_resp_data),
            .fill_en   (rdy_in & fill_any & (victim_q == VW'(w))),
            .fill_tag  (miss_addr_q[ADDR_W-1 -: TAG_W]),
            .inv_all   (rdy_in & inv_all)
        );
    end

    // Merge hit data across ways and find the lowest-numbered invalid way.
    always_comb begin
        hit_any   = 1'b0;
        hit_data  = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_any  = 1'b1;
                hit_data = hit_data | way_rdata[w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = VW'(w);
            end
        end
    end

    // Next-state logic for the refill FSM and the response register.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        k_d          = k_q;
        victim_d     = victim_q;
        kill_d       = kill_q;
        inv_pend_d   = inv_pend_q;
        resp_valid_d = 1'b0;
        resp_inst_d  = resp_inst_q;
        wr_any       = 1'b0;
        fill_any     = 1'b0;
        inv_all      = 1'b0;
        ptr_inc      = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.if_to_ic_invalidate || inv_pend_q) begin
                    inv_all    = 1'b1;
                    inv_pend_d = 1'b0;
                end
                if (accept) begin
                    if (hit_any) begin
                        resp_valid_d = 1'b1;
                        resp_inst_d  = hit_data;
                    end else begin
                        miss_addr_d = bus.if_to_ic_req_addr;
                        k_d         = '0;
                        kill_d      = 1'b0;
                        victim_d    = inv_found ? inv_way : ptr_q[lk_set];
                        ptr_inc     = ~inv_found;
                        state_d     = StRefill;
                    end
                end
            end
            StRefill: begin
                if (bus.if_to_ic_clear)      kill_d     = 1'b1;
                if (bus.if_to_ic_invalidate) inv_pend_d = 1'b1;
                if (bus.mc_to_ic_resp_valid) begin
                    wr_any = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (last_word) begin
                        fill_any = 1'b1;
                        kill_d   = 1'b0;
                        state_d  = StIdle;
                        if (!kill_q && !bus.if_to_ic_clear) begin
                            resp_valid_d = 1'b1;
                            // Earlier words were already written into the victim way.
                            resp_inst_d  = (lk_word == k_q) ? bus.mc_to_ic_resp_data
                                                            : way_rdata[victim_q];
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            miss_addr_q  <= '0;
            k_q          <= '0;
            victim_q     <= '0;
            kill_q       <= 1'b0;
            inv_pend_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            ptr_q        <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            k_q          <= k_d;
            victim_q     <= victim_d;
            kill_q       <= kill_d;
            inv_pend_q   <= inv_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            if (ptr_inc) begin
                ptr_q[lk_set] <= ptr_next;
            end
        end
    end

    assign bus.ic_to_if_req_ready  = ready;
    assign bus.ic_to_if_resp_valid = resp_valid_q;
    assign bus.ic_to_if_resp_inst  = resp_inst_q;
    assign bus.ic_to_mc_req_valid  = (state_q == StRefill);
    assign bus.ic_to_mc_req_addr   = (state_q == StRefill)
                                     ? {miss_addr_q[ADDR_W-1:2+WB], k_q, 2'b00} : '0;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc with a word-at-a-time memory responder.
module tb_icache_assoc;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    icache_assoc_if #(.ADDR_W(32)) bus ();

    icache_assoc #(
        .WAYS       (2),
        .SETS       (64),
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fires = 0;
    int last_fire_cyc = -1;
    int start_fires = 0;
    logic fire_q = 1'b0;
    logic [31:0] addr_log [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'hA0 + {30'd0, a[3:2]};
        return 32'hC0DE0000 ^ a;
    endfunction

    // Count consumed memory words and log their addresses.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        fire_q <= rst_in && rdy_in && bus.ic_to_mc_req_valid && bus.mc_to_ic_resp_valid;
        if (rst_in && rdy_in && bus.ic_to_mc_req_valid && bus.mc_to_ic_resp_valid) begin
            fires <= fires + 1;
            addr_log[fires[5:0]] <= bus.ic_to_mc_req_addr;
            last_fire_cyc <= cyc + 1;
        end
    end

    // Memory controller: one response per outstanding request, held until consumed.
    always @(negedge clk_in) begin
        if (bus.mc_to_ic_resp_valid && (fire_q || !bus.ic_to_mc_req_valid))
            bus.mc_to_ic_resp_valid = 1'b0;
        if (!bus.mc_to_ic_resp_valid && bus.ic_to_mc_req_valid) begin
            bus.mc_to_ic_resp_valid = 1'b1;
            bus.mc_to_ic_resp_data  = mem_word(bus.ic_to_mc_req_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; it must be accepted.
    task automatic issue(input logic [31:0] a);
        @(negedge clk_in);
        bus.if_to_ic_req_valid = 1'b1;
        bus.if_to_ic_req_addr  = a;
        #1;
        chk("ready_on_issue", 32'(bus.ic_to_if_req_ready), 32'd1);
        start_fires = fires;
        @(negedge clk_in);
        bus.if_to_ic_req_valid = 1'b0;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] exp);
        chk({tag, "_hit_valid"}, 32'(bus.ic_to_if_resp_valid), 32'd1);
        chk({tag, "_hit_inst"}, bus.ic_to_if_resp_inst, exp);
        chk({tag, "_hit_no_mc"}, 32'(fires - start_fires), 32'd0);
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] exp);
        chk({tag, "_busy"}, 32'(bus.ic_to_if_req_ready), 32'd0);
        for (int i = 0; i < 100 && !bus.ic_to_if_resp_valid; i++) @(negedge clk_in);
        chk({tag, "_miss_valid"}, 32'(bus.ic_to_if_resp_valid), 32'd1);
        chk({tag, "_miss_inst"}, bus.ic_to_if_resp_inst, exp);
        chk({tag, "_miss_words"}, 32'(fires - start_fires), 32'd4);
        chk({tag, "_miss_latency"}, 32'(last_fire_cyc), 32'(cyc));
    endtask

    task automatic wait_fires(input int target);
        for (int i = 0; i < 100 && fires < target; i++) @(negedge clk_in);
        chk("wait_fires", 32'(fires), 32'(target));
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        bus.if_to_ic_req_valid  = 1'b0;
        bus.if_to_ic_req_addr   = '0;
        bus.if_to_ic_clear      = 1'b0;
        bus.if_to_ic_invalidate = 1'b0;
        bus.mc_to_ic_resp_valid = 1'b0;
        bus.mc_to_ic_resp_data  = '0;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_resp_valid", 32'(bus.ic_to_if_resp_valid), 32'd0);
        chk("rst_resp_inst", bus.ic_to_if_resp_inst, 32'd0);
        chk("rst_req_valid", 32'(bus.ic_to_mc_req_valid), 32'd0);
        chk("rst_req_addr", bus.ic_to_mc_req_addr, 32'd0);
        chk("rst_ready", 32'(bus.ic_to_if_req_ready), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("ready_after_rst", 32'(bus.ic_to_if_req_ready), 32'd1);

        // Cold miss then hit in the same line
        issue(32'h1008);
        expect_miss("cold", 32'hA2);
        chk("cold_addr0", addr_log[start_fires[5:0]], 32'h1000);
        chk("cold_addr1", addr_log[6'(start_fires + 1)], 32'h1004);
        chk("cold_addr2", addr_log[6'(start_fires + 2)], 32'h1008);
        chk("cold_addr3", addr_log[6'(start_fires + 3)], 32'h100C);
        issue(32'h100C);
        expect_hit("warm", 32'hA3);

        // Conflict in set 0: third line evicts way 0
        issue(32'h2400);
        expect_miss("conf_fill1", 32'hC0DE2400);
        issue(32'h3800);
        expect_miss("conf_evict", 32'hC0DE3800);
        issue(32'h2400);
        expect_hit("conf_keep", 32'hC0DE2400);
        issue(32'h1000);
        expect_miss("conf_gone", 32'hA0);
        issue(32'h3800);
        expect_hit("conf_new", 32'hC0DE3800);

        // Four back-to-back hits
        @(negedge clk_in);
        start_fires = fires;
        bus.if_to_ic_req_valid = 1'b1;
        bus.if_to_ic_req_addr  = 32'h1000;
        #1 chk("b2b_ready0", 32'(bus.ic_to_if_req_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk_in);
            chk("b2b_valid", 32'(bus.ic_to_if_resp_valid), 32'd1);
            chk("b2b_inst", bus.ic_to_if_resp_inst, 32'hA0 + 32'(i - 1));
            bus.if_to_ic_req_addr = 32'h1000 + 32'(4 * i);
            #1 chk("b2b_ready", 32'(bus.ic_to_if_req_ready), 32'd1);
        end
        @(negedge clk_in);
        bus.if_to_ic_req_valid = 1'b0;
        expect_hit("b2b_last", 32'hA3);

        // Invalidate in idle blocks requests for that cycle
        @(negedge clk_in);
        bus.if_to_ic_invalidate = 1'b1;
        #1 chk("inv_ready", 32'(bus.ic_to_if_req_ready), 32'd0);
        @(negedge clk_in);
        bus.if_to_ic_invalidate = 1'b0;

        // Clear mid-refill: line installs, no response
        issue(32'h1008);
        wait_fires(start_fires + 2);
        bus.if_to_ic_clear = 1'b1;
        @(negedge clk_in);
        bus.if_to_ic_clear = 1'b0;
        wait_fires(start_fires + 4);
        chk("kill_no_resp", 32'(bus.ic_to_if_resp_valid), 32'd0);
        @(negedge clk_in);
        chk("kill_no_resp2", 32'(bus.ic_to_if_resp_valid), 32'd0);

        // Clear beats a same-cycle request
        start_fires = fires;
        bus.if_to_ic_req_valid = 1'b1;
        bus.if_to_ic_req_addr  = 32'h1008;
        bus.if_to_ic_clear     = 1'b1;
        #1 chk("clr_prio_ready", 32'(bus.ic_to_if_req_ready), 32'd0);
        @(negedge clk_in);
        bus.if_to_ic_req_valid = 1'b0;
        bus.if_to_ic_clear     = 1'b0;
        chk("clr_prio_no_resp", 32'(bus.ic_to_if_resp_valid), 32'd0);
        chk("clr_prio_no_mc", 32'(bus.ic_to_mc_req_valid), 32'd0);
        issue(32'h1008);
        expect_hit("after_kill", 32'hA2);

        // Invalidate mid-refill: response still returned, then everything invalid
        issue(32'h2400);
        wait_fires(start_fires + 1);
        bus.if_to_ic_invalidate = 1'b1;
        @(negedge clk_in);
        bus.if_to_ic_invalidate = 1'b0;
        expect_miss("inv_mid", 32'hC0DE2400);
        chk("inv_pending_ready", 32'(bus.ic_to_if_req_ready), 32'd0);
        issue(32'h1000);
        expect_miss("inv_refetch", 32'hA0);

        // rdy_in low mid-refill holds the memory request
        issue(32'h3800);
        wait_fires(start_fires + 1);
        rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk("stall_req_valid", 32'(bus.ic_to_mc_req_valid), 32'd1);
            chk("stall_req_addr", bus.ic_to_mc_req_addr, 32'h3804);
            chk("stall_no_progress", 32'(fires - start_fires), 32'd1);
        end
        rdy_in = 1'b1;
        expect_miss("stall", 32'hC0DE3800);

        // Reset mid-refill abandons the transaction
        issue(32'h2400);
        wait_fires(start_fires + 2);
        rst_in = 1'b0;
        #1;
        chk("rst_mid_req_valid", 32'(bus.ic_to_mc_req_valid), 32'd0);
        chk("rst_mid_req_addr", bus.ic_to_mc_req_addr, 32'd0);
        chk("rst_mid_ready", 32'(bus.ic_to_if_req_ready), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        issue(32'h2400);
        expect_miss("post_rst", 32'hC0DE2400);
        issue(32'h1000);
        expect_miss("post_rst_cold", 32'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache with multi-word lines, sitting between instruction fetch and the memory controller. Hits are answered one cycle after the request. Misses start a refill FSM that fetches the whole line word by word, installs it with round-robin replacement, then answers the request. Also supports a response kill on redirect and a whole-cache invalidate.

## Interface
- WAYS, 2: associativity, power of two, ≥1
- SETS, 64: sets per way, power of two
- LINE_WORDS, 4: 32-bit words per line, power of two, ≥2
- ADDR_W, 32: address width
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low freezes all state and outputs
- if_to_ic_req_valid  in  1  fetch request
- if_to_ic_req_addr  in  ADDR_W  word-aligned fetch address; bits [1:0] ignored
- ic_to_if_req_ready  out  1  request accepted when valid&ready
- ic_to_if_resp_valid  out  1  one-cycle response strobe
- ic_to_if_resp_inst  out  32  instruction word
- if_to_ic_clear  in  1  redirect: kill the pending response
- if_to_ic_invalidate  in  1  clear all valid bits (fence.i)
- ic_to_mc_req_valid  out  1  word read request
- ic_to_mc_req_addr  out  ADDR_W  word read address
- mc_to_ic_resp_valid  in  1  read data strobe
- mc_to_ic_resp_data  in  32  read data

## Operation
- Address split: [1:0] byte offset; [2 +: WB] word (WB=log2 LINE_WORDS); [2+WB +: SB] set (SB=log2 SETS); remaining high bits are the tag.
- Per set: WAYS × (valid, tag, LINE_WORDS data words), plus one log2(WAYS)-bit victim pointer.
- FSM states: IDLE, REFILL.
- ready = rdy_in & state==IDLE & !clear & !invalidate & !inv_pending.
- IDLE, accepted request:
  - Tag compare runs across all ways.
  - Hit: the word is registered and resp_valid asserts next cycle.
  - Miss: latch the address and go to REFILL.
- REFILL:
  - req_valid stays high. req_addr = line base + 4·k, k = 0..LINE_WORDS-1 in ascending order, one request outstanding.
  - Each mc_to_ic_resp_valid writes the word into the victim way and advances k.
  - After the last word: tag and valid are set, the response is issued with the requested word, and the FSM goes to IDLE.
- Victim choice: the lowest-numbered invalid way. If all ways are valid, the way at the victim pointer is used and the pointer is incremented mod WAYS. The victim is chosen when entering REFILL.
- Clear:
  - Suppresses the response due next cycle.
  - During REFILL it sets kill: the refill still completes and installs the line, but no response is issued.
  - Clear has priority over a same-cycle request, which is not accepted.
- Invalidate:
  - In IDLE, all valid bits are cleared at the next edge.
  - During REFILL it sets inv_pending. This is applied on the edge after the line installs, so the new line is invalidated too.
- Reset (asynchronous):
  - Cleared: state=IDLE; all valid bits, victim pointers, kill and inv_pending = 0.
  - Outputs are 0 while reset is asserted: resp_valid, resp_inst, req_valid, req_addr, ready.
  - Data and tag arrays are not reset.
  - Reset mid-refill abandons the transaction.

## Timing
- Hit latency: 1 cycle. Back-to-back hits sustain one request per cycle.
- Miss latency: response appears the cycle after the LINE_WORDS-th mc_to_ic_resp_valid. ready is low from the cycle after acceptance until IDLE resumes.
- Memory handshake: req_valid/req_addr are stable until mc_to_ic_resp_valid. The next address is presented the cycle after a response. The controller must never send a response with no request outstanding.
- rdy_in low: no state changes and outputs are held. Refill progress pauses.
- Simultaneous clear and invalidate in IDLE: both apply.

## Structure
- Shared def.v gains: `ICACHE_WAYS, `ICACHE_SETS, `ICACHE_LINE_WORDS defaults; address-field range macros derived from them; FSM state encodings.
- Sub-module icache_way: one way's valid/tag/data storage, hit compare and word read/write ports, instantiated WAYS times by a generate loop. The top level holds the FSM, victim pointers and the response register.

## Test plan
Defaults assumed (set = addr[9:4], word = addr[3:2]).
- Cold miss at 0x1008 -> mc addrs 0x1000, 0x1004, 0x1008, 0x100C, memory returns 0xA0..0xA3. resp_inst=0xA2 one cycle after the 4th strobe. A following request to 0x100C hits and returns 0xA3 at T+1 with no mc traffic.
- Conflict in set 0: fill 0x1000 (way 0), 0x2400 (way 1), then 0x3800 evicts way 0. After that, 0x2400 hits and 0x1000 misses.
- Four consecutive hit requests -> resp_valid high four consecutive cycles with matching words, and ready stays high.
- Clear asserted mid-refill of 0x1008 -> all 4 words fetched, no resp_valid. A later request to 0x1008 hits with 1-cycle latency.
- Invalidate mid-refill -> refill completes and returns its response. Afterwards a request to 0x1000 misses and re-fetches.
- rdy_in low 3 cycles mid-refill -> req_addr and outputs held, then refill resumes. rst_in pulsed low mid-refill -> req_valid drops immediately, and the next request to the same line misses.
